fwd_scoreboard: RTL and testbench

- Parametrised operand-forwarding unit for the integer pipeline; generalises the single-operand, fixed three-way forward select to NUM_SRC operands and DEPTH in-flight stages.
- Sits at the ID/EX boundary and keeps its own shift register of in-flight destination tags, one entry per post-issue stage (entry 0 = EX, 1 = MEM, 2 = WB for the default).
- Per source operand it selects register-file data or the youngest in-flight result.
- Raises hazard_stall when the youngest producer's result is not yet available (load-use and longer).

---
 rtl/fwd_scoreboard_if.sv | 34 +++
 rtl/fwd_scoreboard.sv | 136 +++++++++++++
 tb/tb_fwd_scoreboard.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Bundle of the ID/EX forwarding signals: the pipeline side (master) drives the issue,
// flush and operand lookup; the scoreboard (slave) returns forwarded data and the stall.
interface fwd_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int RA_W    = 5,
    parameter int SW      = $clog2(DEPTH)
);
    logic                    advance;
    logic                    issue_valid;
    logic                    issue_we;
    logic [RA_W-1:0]         issue_rd;
    logic [SW-1:0]           issue_ready_stage;
    logic [DEPTH-1:0]        flush_mask;
    logic [NUM_SRC*RA_W-1:0] rs_addr;
    logic [NUM_SRC*XLEN-1:0] rf_data;
    logic [DEPTH*XLEN-1:0]   stage_data;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic [NUM_SRC-1:0]      src_fwd;
    logic                    hazard_stall;

    modport master (
        output advance, issue_valid, issue_we, issue_rd, issue_ready_stage, flush_mask,
        output rs_addr, rf_data, stage_data,
        input  src_data, src_fwd, hazard_stall
    );

    modport slave (
        input  advance, issue_valid, issue_we, issue_rd, issue_ready_stage, flush_mask,
        input  rs_addr, rf_data, stage_data,
        output src_data, src_fwd, hazard_stall
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: tracks DEPTH in-flight destination tags and picks the youngest
// producer per source operand. Optional perf counters are enabled with FWD_PERF_CNT_EN.
module fwd_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int RA_W    = 5,
    parameter int SW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_scoreboard_if.slave    bus
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_fwd_cnt
`endif
);
    localparam logic [SW-1:0] LAST_IDX = SW'(DEPTH - 1);

    logic            r_valid [DEPTH];
    logic [RA_W-1:0] r_rd    [DEPTH];
    logic [SW-1:0]   r_rdy   [DEPTH];

    logic [NUM_SRC-1:0]      w_fwd_vec;
    logic [NUM_SRC-1:0]      w_stall_vec;
    logic [NUM_SRC*XLEN-1:0] w_data_vec;
    logic                    w_stall_any;
    logic                    w_new_valid;
    logic [SW-1:0]           w_new_rdy;

    assign w_stall_any = |w_stall_vec;
    assign w_new_rdy   = (bus.issue_ready_stage > LAST_IDX) ? LAST_IDX : bus.issue_ready_stage;
    // A stalled ID instruction is not actually issued, so it enters EX as a bubble.
    assign w_new_valid = bus.issue_valid & bus.issue_we & (bus.issue_rd != '0)
                       & ~w_stall_any & ~bus.flush_mask[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_rd[i]    <= '0;
                r_rdy[i]   <= '0;
            end
        end else if (bus.advance) begin
            r_valid[0] <= w_new_valid;
            r_rd[0]    <= bus.issue_rd;
            r_rdy[0]   <= w_new_rdy;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1] & ~bus.flush_mask[i-1];
                r_rd[i]    <= r_rd[i-1];
                r_rdy[i]   <= r_rdy[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i] & ~bus.flush_mask[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [RA_W-1:0] w_rs;
            logic            w_zero;
            logic            w_hit;
            logic [SW-1:0]   w_idx;
            logic [SW-1:0]   w_rdy;
            logic [XLEN-1:0] w_sdata;

            assign w_rs   = bus.rs_addr[gi*RA_W +: RA_W];
            assign w_zero = (w_rs == '0);

            // Scan oldest to youngest so the lowest matching index overrides.
            always_comb begin
                w_hit   = 1'b0;
                w_idx   = '0;
                w_rdy   = '0;
                w_sdata = '0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (r_valid[i] && (r_rd[i] == w_rs)) begin
                        w_hit   = 1'b1;
                        w_idx   = SW'(i);
                        w_rdy   = r_rdy[i];
                        w_sdata = bus.stage_data[i*XLEN +: XLEN];
                    end
                end
            end

            assign w_fwd_vec[gi]   = w_hit & ~w_zero & (w_idx >= w_rdy);
            assign w_stall_vec[gi] = w_hit & ~w_zero & (w_idx < w_rdy);
            assign w_data_vec[gi*XLEN +: XLEN] = w_zero        ? '0      :
                                                 w_fwd_vec[gi] ? w_sdata :
                                                 bus.rf_data[gi*XLEN +: XLEN];
        end
    endgenerate

    assign bus.src_data     = w_data_vec;
    assign bus.src_fwd      = w_fwd_vec;
    assign bus.hazard_stall = w_stall_any;

`ifdef FWD_PERF_CNT_EN
    localparam int PW = $clog2(NUM_SRC + 1);

    logic [31:0]   r_perf_stall;
    logic [31:0]   r_perf_fwd;
    logic [PW-1:0] w_fwd_pop;
    logic [32:0]   w_fwd_sum;

    always_comb begin
        w_fwd_pop = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            w_fwd_pop = w_fwd_pop + PW'(w_fwd_vec[j]);
        end
    end

    assign w_fwd_sum = {1'b0, r_perf_fwd} + {{(33-PW){1'b0}}, w_fwd_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_fwd   <= '0;
        end else begin
            if (w_stall_any && bus.advance && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (bus.issue_valid && bus.advance && !w_stall_any) begin
                r_perf_fwd <= w_fwd_sum[32] ? 32'hFFFF_FFFF : w_fwd_sum[31:0];
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_fwd_cnt   = r_perf_fwd;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus randomized traffic checked
// against a queue-based model of the in-flight pipeline.
module tb_fwd_scoreboard;
    localparam int XLEN    = 32;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int RA_W    = 5;
    localparam int SW      = $clog2(DEPTH);

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;
`endif

    fwd_scoreboard_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .RA_W(RA_W), .SW(SW)) bus ();

    fwd_scoreboard #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .RA_W(RA_W), .SW(SW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef FWD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: pipeline as a queue, index 0 = youngest (EX).
    typedef struct {
        bit v;
        int rd;
        int rdy;
    } ent_t;

    ent_t    mq[$];
    longint  m_stall_cnt;
    longint  m_fwd_cnt;

    function automatic void m_reset();
        ent_t e;
        e.v = 0; e.rd = 0; e.rdy = 0;
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back(e);
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
    endfunction

    function automatic void m_eval(output logic [NUM_SRC*XLEN-1:0] d,
                                   output logic [NUM_SRC-1:0] f,
                                   output logic [NUM_SRC-1:0] s);
        d = bus.rf_data;
        f = '0;
        s = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            int rs;
            int idx;
            rs  = int'(bus.rs_addr[j*RA_W +: RA_W]);
            idx = -1;
            if (rs == 0) begin
                d[j*XLEN +: XLEN] = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (idx < 0 && mq[i].v && mq[i].rd == rs) idx = i;
                end
                if (idx >= 0) begin
                    if (idx >= mq[idx].rdy) begin
                        f[j] = 1'b1;
                        d[j*XLEN +: XLEN] = bus.stage_data[idx*XLEN +: XLEN];
                    end else begin
                        s[j] = 1'b1;
                    end
                end
            end
        end
    endfunction

    function automatic void m_update();
        logic [NUM_SRC*XLEN-1:0] d;
        logic [NUM_SRC-1:0]      f;
        logic [NUM_SRC-1:0]      s;
        ent_t                    n;
        m_eval(d, f, s);
        if (bus.advance && (|s)) m_stall_cnt = (m_stall_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall_cnt + 1;
        if (bus.issue_valid && bus.advance && !(|s)) begin
            m_fwd_cnt = m_fwd_cnt + $countones(f);
            if (m_fwd_cnt > 64'hFFFF_FFFF) m_fwd_cnt = 64'hFFFF_FFFF;
        end
        for (int i = 0; i < DEPTH; i++) if (bus.flush_mask[i]) mq[i].v = 0;
        if (bus.advance) begin
            n.v   = bus.issue_valid && bus.issue_we && (bus.issue_rd != 0) && !(|s) && !bus.flush_mask[0];
            n.rd  = int'(bus.issue_rd);
            n.rdy = (int'(bus.issue_ready_stage) > DEPTH - 1) ? DEPTH - 1 : int'(bus.issue_ready_stage);
            mq.push_front(n);
            void'(mq.pop_back());
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.advance           = 1'b0;
        bus.issue_valid       = 1'b0;
        bus.issue_we          = 1'b0;
        bus.issue_rd          = '0;
        bus.issue_ready_stage = '0;
        bus.flush_mask        = '0;
        bus.rs_addr           = '0;
        bus.rf_data           = {$urandom, $urandom};
        bus.stage_data        = {$urandom, $urandom, $urandom};
    endtask

    task automatic set_rs(input int j, input logic [RA_W-1:0] a);
        bus.rs_addr[j*RA_W +: RA_W] = a;
    endtask

    task automatic issue(input logic [RA_W-1:0] rd, input logic [SW-1:0] rdy);
        set_idle();
        bus.advance           = 1'b1;
        bus.issue_valid       = 1'b1;
        bus.issue_we          = 1'b1;
        bus.issue_rd          = rd;
        bus.issue_ready_stage = rdy;
        tick();
    endtask

    task automatic clear();
        set_idle();
        bus.flush_mask = '1;
        tick();
    endtask

    function automatic logic [XLEN-1:0] got_data(input int j);
        return bus.src_data[j*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rf_of(input int j);
        return bus.rf_data[j*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] stage_of(input int i);
        return bus.stage_data[i*XLEN +: XLEN];
    endfunction

    task automatic test_reset();
        set_idle();
        set_rs(0, 5'd5);
        set_rs(1, 5'd0);
        #1;
        checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.hazard_stall); end
        checks++; if (bus.src_fwd !== 2'b00) begin failures++; $display("FAIL reset_fwd got=%b exp=00", bus.src_fwd); end
        checks++; if (got_data(0) !== rf_of(0)) begin failures++; $display("FAIL reset_data0 got=%h exp=%h", got_data(0), rf_of(0)); end
        checks++; if (got_data(1) !== 32'h0) begin failures++; $display("FAIL reset_data1_x0 got=%h exp=0", got_data(1)); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (perf_stall_cnt !== 32'h0 || perf_fwd_cnt !== 32'h0) begin failures++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_stall_cnt, perf_fwd_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_alu_b2b();
        clear();
        issue(5'd5, 2'd0);
        set_idle();
        bus.advance = 1'b1;
        set_rs(0, 5'd5);
        bus.stage_data[0 +: XLEN] = 32'h1234;
        #1;
        checks++; if (got_data(0) !== 32'h1234) begin failures++; $display("FAIL alu_data got=%h exp=00001234", got_data(0)); end
        checks++; if (bus.src_fwd[0] !== 1'b1) begin failures++; $display("FAIL alu_fwd got=%b exp=1", bus.src_fwd[0]); end
        checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", bus.hazard_stall); end
        tick();
        $display("alu_b2b: data=%h fwd=%b", got_data(0), bus.src_fwd);
    endtask

    task automatic test_load_use();
        clear();
        issue(5'd6, 2'd1);
        set_idle();
        bus.advance     = 1'b1;
        bus.issue_valid = 1'b1;
        set_rs(1, 5'd6);
        #1;
        checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%b exp=1", bus.hazard_stall); end
        tick();
        bus.stage_data[XLEN +: XLEN] = 32'hBEEF;
        #1;
        checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL load_use_release got=%b exp=0", bus.hazard_stall); end
        checks++; if (got_data(1) !== 32'hBEEF) begin failures++; $display("FAIL load_use_data got=%h exp=0000beef", got_data(1)); end
        checks++; if (bus.src_fwd[1] !== 1'b1) begin failures++; $display("FAIL load_use_fwd got=%b exp=1", bus.src_fwd[1]); end
        tick();
        $display("load_use: data1=%h", got_data(1));
    endtask

    task automatic test_youngest();
        clear();
        issue(5'd7, 2'd0);
        issue(5'd7, 2'd0);
        set_idle();
        set_rs(0, 5'd7);
        bus.stage_data[0 +: XLEN]    = 32'hA;
        bus.stage_data[XLEN +: XLEN] = 32'hB;
        #1;
        checks++; if (got_data(0) !== 32'hA) begin failures++; $display("FAIL youngest_data got=%h exp=0000000a", got_data(0)); end
        tick();
        $display("youngest: data0=%h", got_data(0));
    endtask

    task automatic test_x0_nonwriter();
        clear();
        issue(5'd0, 2'd0);
        set_idle();
        bus.advance     = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        tick();
        set_idle();
        set_rs(0, 5'd0);
        set_rs(1, 5'd3);
        #1;
        checks++; if (got_data(0) !== 32'h0) begin failures++; $display("FAIL x0_data got=%h exp=0", got_data(0)); end
        checks++; if (got_data(1) !== rf_of(1)) begin failures++; $display("FAIL nonwriter_data got=%h exp=%h", got_data(1), rf_of(1)); end
        checks++; if (bus.src_fwd !== 2'b00 || bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL x0_fwd_stall got=%b/%b exp=00/0", bus.src_fwd, bus.hazard_stall); end
        tick();
        $display("x0_nonwriter: fwd=%b", bus.src_fwd);
    endtask

    task automatic test_flush_hold();
        clear();
        issue(5'd9, 2'd1);
        set_idle();
        set_rs(0, 5'd9);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL hold_stall cyc=%0d got=%b exp=1", k, bus.hazard_stall); end
            tick();
        end
        bus.flush_mask = 3'b001;
        #1;
        checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL flush_sync got=%b exp=1", bus.hazard_stall); end
        tick();
        bus.flush_mask = '0;
        #1;
        checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL flush_release got=%b exp=0", bus.hazard_stall); end
        checks++; if (got_data(0) !== rf_of(0) || bus.src_fwd[0] !== 1'b0) begin failures++; $display("FAIL flush_data got=%h/%b exp=%h/0", got_data(0), bus.src_fwd[0], rf_of(0)); end
        $display("flush_hold: stall=%b", bus.hazard_stall);
    endtask

    task automatic test_clamp();
        clear();
        issue(5'd10, 2'd3);
        set_idle();
        bus.advance = 1'b1;
        set_rs(0, 5'd10);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL clamp_stall idx=%0d got=%b exp=1", k, bus.hazard_stall); end
            tick();
        end
        #1;
        checks++; if (bus.hazard_stall !== 1'b0 || bus.src_fwd[0] !== 1'b1 || got_data(0) !== stage_of(2)) begin
            failures++; $display("FAIL clamp_fwd got=%b/%b/%h exp=0/1/%h", bus.hazard_stall, bus.src_fwd[0], got_data(0), stage_of(2));
        end
        tick();
        #1;
        checks++; if (bus.src_fwd[0] !== 1'b0 || got_data(0) !== rf_of(0)) begin failures++; $display("FAIL clamp_falloff got=%b/%h exp=0/%h", bus.src_fwd[0], got_data(0), rf_of(0)); end
        $display("clamp: last-stage forward and fall-off done");
    endtask

    task automatic test_random();
        logic [NUM_SRC*XLEN-1:0] ed;
        logic [NUM_SRC-1:0]      ef;
        logic [NUM_SRC-1:0]      es;
        int                      nfail0;
        clear();
        for (int n = 0; n < 400; n++) begin
            nfail0 = failures;
            bus.advance           = ($urandom_range(0, 3) != 0);
            bus.issue_valid       = $urandom_range(0, 1);
            bus.issue_we          = ($urandom_range(0, 3) != 0);
            bus.issue_rd          = RA_W'($urandom_range(0, 7));
            bus.issue_ready_stage = SW'($urandom_range(0, 3));
            for (int i = 0; i < DEPTH; i++) bus.flush_mask[i] = ($urandom_range(0, 7) == 0);
            for (int j = 0; j < NUM_SRC; j++) set_rs(j, RA_W'($urandom_range(0, 7)));
            bus.rf_data    = {$urandom, $urandom};
            bus.stage_data = {$urandom, $urandom, $urandom};
            #1;
            m_eval(ed, ef, es);
            checks++; if (bus.hazard_stall !== (|es)) begin failures++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, bus.hazard_stall, |es); end
            checks++; if (bus.src_fwd !== ef) begin failures++; $display("FAIL rand_fwd n=%0d got=%b exp=%b", n, bus.src_fwd, ef); end
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!es[j]) begin
                    checks++;
                    if (got_data(j) !== ed[j*XLEN +: XLEN]) begin
                        failures++; $display("FAIL rand_data n=%0d op=%0d got=%h exp=%h", n, j, got_data(j), ed[j*XLEN +: XLEN]);
                    end
                end
            end
`ifdef FWD_PERF_CNT_EN
            checks++; if (perf_stall_cnt !== m_stall_cnt[31:0]) begin failures++; $display("FAIL rand_perf_stall n=%0d got=%0d exp=%0d", n, perf_stall_cnt, m_stall_cnt); end
            checks++; if (perf_fwd_cnt !== m_fwd_cnt[31:0]) begin failures++; $display("FAIL rand_perf_fwd n=%0d got=%0d exp=%0d", n, perf_fwd_cnt, m_fwd_cnt); end
`endif
            if (n % 50 == 0 || failures != nfail0)
                $display("random n=%0d adv=%b iss=%b rd=%0d rs=%h stall=%b fwd=%b", n, bus.advance, bus.issue_valid, bus.issue_rd, bus.rs_addr, bus.hazard_stall, bus.src_fwd);
            tick();
        end
    endtask

    task automatic test_async_reset();
        clear();
        issue(5'd9, 2'd1);
        set_idle();
        bus.advance     = 1'b1;
        bus.issue_valid = 1'b1;
        set_rs(0, 5'd9);
        set_rs(1, 5'd9);
        #1;
        checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL areset_pre_stall got=%b exp=1", bus.hazard_stall); end
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL areset_stall got=%b exp=0", bus.hazard_stall); end
        checks++; if (bus.src_fwd !== 2'b00 || got_data(0) !== rf_of(0)) begin failures++; $display("FAIL areset_data got=%b/%h exp=00/%h", bus.src_fwd, got_data(0), rf_of(0)); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (perf_stall_cnt !== 32'h0 || perf_fwd_cnt !== 32'h0) begin failures++; $display("FAIL areset_perf got=%h/%h exp=0/0", perf_stall_cnt, perf_fwd_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL areset_after got=%b exp=0", bus.hazard_stall); end
        $display("async_reset: stall=%b fwd=%b", bus.hazard_stall, bus.src_fwd);
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        m_reset();
        set_idle();
        #1;
        test_reset();
        test_alu_b2b();
        test_load_use();
        test_youngest();
        test_x0_nonwriter();
        test_flush_hold();
        test_clamp();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
